// File: rtl/mprj_pad_pkg.sv
// Shared definitions for the MPRJ pad DM configuration loader.
// Holds the supported DM codes, the loader state encoding and the DM sanitizer.
package mprj_pad_pkg;

    localparam logic [2:0] DM_IN_NOPULL = 3'b001;
    localparam logic [2:0] DM_IN_PULLUP = 3'b010;
    localparam logic [2:0] DM_IN_PULLDN = 3'b011;
    localparam logic [2:0] DM_OUT       = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SHIFT,
        ST_LOAD
    } state_e;

    // Returns {illegal, dm}; unsupported codes fall back to plain input mode.
    function automatic logic [3:0] dm_sanitize(input logic [2:0] dm);
        case (dm)
            DM_IN_NOPULL, DM_IN_PULLUP, DM_IN_PULLDN, DM_OUT: dm_sanitize = {1'b0, dm};
            default:                                          dm_sanitize = {1'b1, DM_IN_NOPULL};
        endcase
    endfunction

endpackage

// File: rtl/mprj_cfg_clkdiv.sv
// Serial clock phase generator: each phase (low, then high) lasts CLK_DIV cycles.
// Clearing forces the low phase with a fresh count.
module mprj_cfg_clkdiv #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic phase_end,
    output logic phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign phase_end = en && (cnt_q == CW'(CLK_DIV - 1));
    assign phase     = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (phase_end) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/mprj_pad_cfg_loader.sv
// Shifts one sanitized 3-bit DM code per pad into the padframe chain, highest pad
// first and MSB first, then strobes serial_load to commit the chain.
module mprj_pad_cfg_loader #(
    parameter int  NUM_PADS    = 38,
    parameter int  CLK_DIV     = 2,
    parameter int  LOAD_CYCLES = 4,
    localparam int AW          = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] cfg_addr,
    input  logic [2:0]    cfg_rdata,
    output logic          serial_clock,
    output logic          serial_data,
    output logic          serial_load,
    output logic          busy,
    output logic          done,
    output logic          cfg_illegal
);

    import mprj_pad_pkg::*;

    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   pad_idx_q, pad_idx_d;
    logic [2:0]      shreg_q, shreg_d;
    logic [1:0]      bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]   load_cnt_q, load_cnt_d;
    logic            done_q, done_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      sanitized;
    logic            phase_end;
    logic            phase;
    logic            bit_end;

    // Clearing whenever SHIFT is left (including abort) keeps serial_clock low outside SHIFT.
    mprj_cfg_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .clr       (state_d != ST_SHIFT),
        .en        (state_q == ST_SHIFT),
        .phase_end (phase_end),
        .phase     (phase)
    );

    assign sanitized = dm_sanitize(cfg_rdata);
    assign bit_end   = phase_end && phase;

    always_comb begin
        state_d    = state_q;
        pad_idx_d  = pad_idx_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        load_cnt_d = load_cnt_q;
        done_d     = 1'b0;
        illegal_d  = illegal_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_FETCH;
                        pad_idx_d = AW'(NUM_PADS - 1);
                        illegal_d = 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    shreg_d   = sanitized[2:0];
                    bit_cnt_d = 2'd2;
                    if (sanitized[3]) begin
                        illegal_d = 1'b1;
                    end
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Data only advances after the high phase, so it is stable for the whole bit.
                    if (bit_end) begin
                        shreg_d = {shreg_q[1:0], 1'b0};
                        if (bit_cnt_q == 2'd0) begin
                            if (pad_idx_q == '0) begin
                                state_d    = ST_LOAD;
                                load_cnt_d = '0;
                            end else begin
                                pad_idx_d = pad_idx_q - 1'b1;
                                state_d   = ST_FETCH;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_cnt_q == LW'(LOAD_CYCLES - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            pad_idx_q  <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            load_cnt_q <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_idx_q  <= pad_idx_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            load_cnt_q <= load_cnt_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
        end
    end

    assign cfg_addr     = pad_idx_q;
    assign serial_clock = phase;
    assign serial_data  = (state_q == ST_SHIFT) && shreg_q[2];
    assign serial_load  = (state_q == ST_LOAD);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign cfg_illegal  = illegal_q;

endmodule

// File: tb/tb_mprj_pad_cfg_loader.sv
// Randomized scoreboard bench for the pad DM chain loader: stimulus queues expected
// serial bits and done events, an independent monitor checks them as they appear.
module tb_mprj_pad_cfg_loader;

    localparam int NP    = 3;
    localparam int CD    = 2;
    localparam int LC    = 3;
    localparam int AW    = $clog2(NP);
    localparam int PAD_T = 2 + 6 * CD;
    localparam int RUN_T = 1 + NP * PAD_T + LC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] cfg_addr;
    logic [2:0]    cfg_rdata;
    logic          serial_clock;
    logic          serial_data;
    logic          serial_load;
    logic          busy;
    logic          done;
    logic          cfg_illegal;

    logic [2:0] cfg_mem [NP];

    typedef struct {
        int   cyc;
        logic val;
    } bit_exp_t;

    typedef struct {
        int   cyc;
        logic ill;
    } done_exp_t;

    bit_exp_t  exp_bits [$];
    done_exp_t exp_done [$];

    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   load_len  = 0;
    int   done_seen = 0;
    logic prev_sclk = 1'b0;
    logic rise_val  = 1'b0;

    mprj_pad_cfg_loader #(
        .NUM_PADS    (NP),
        .CLK_DIV     (CD),
        .LOAD_CYCLES (LC)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start        (start),
        .abort        (abort),
        .cfg_addr     (cfg_addr),
        .cfg_rdata    (cfg_rdata),
        .serial_clock (serial_clock),
        .serial_data  (serial_data),
        .serial_load  (serial_load),
        .busy         (busy),
        .done         (done),
        .cfg_illegal  (cfg_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Config register bank with a registered read port.
    always @(posedge clk) cfg_rdata <= cfg_mem[cfg_addr];

    function automatic logic ref_ill(input logic [2:0] c);
        return !(c inside {3'b001, 3'b010, 3'b011, 3'b110});
    endfunction

    function automatic logic [2:0] ref_dm(input logic [2:0] c);
        return ref_ill(c) ? 3'b001 : c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT shows a serial edge or a done pulse.
    initial begin
        bit_exp_t  be;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (serial_load) begin
                load_len++;
                chk("sclk_low_in_load", int'(serial_clock), 0);
            end
            if (serial_clock && !prev_sclk) begin
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_edge: got rising serial_clock expected none (cycle %0d)", cyc);
                end else begin
                    be = exp_bits.pop_front();
                    chk("bit_val", int'(serial_data), int'(be.val));
                    chk("bit_cycle", cyc, be.cyc);
                end
                rise_val = serial_data;
            end else if (serial_clock) begin
                chk("data_stable", int'(serial_data), int'(rise_val));
            end
            prev_sclk = serial_clock;
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    de = exp_done.pop_front();
                    chk("done_cycle", cyc, de.cyc);
                    chk("illegal_at_done", int'(cfg_illegal), int'(de.ill));
                    chk("load_len", load_len, LC);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    // One load; abort_at/restart_at/reset_at are cycle offsets from start (-1 = unused).
    task automatic run_load(input int abort_at, input int restart_at, input int reset_at);
        int       s;
        int       cut;
        int       rise;
        int       d0;
        logic [2:0] code;
        logic     ill;
        logic     ill_first;
        bit_exp_t be;
        done_exp_t de;
        @(negedge clk);
        s   = cyc;
        d0  = done_seen;
        cut = (abort_at >= 0) ? abort_at : ((reset_at >= 0) ? reset_at : RUN_T);
        ill = 1'b0;
        ill_first = ref_ill(cfg_mem[NP-1]);
        for (int k = 0; k < NP; k++) begin
            code = ref_dm(cfg_mem[NP-1-k]);
            if (2 + k * PAD_T <= cut) ill = ill | ref_ill(cfg_mem[NP-1-k]);
            for (int b = 0; b < 3; b++) begin
                rise = 3 + k * PAD_T + 2 * CD * b + CD;
                if (rise <= cut) begin
                    be.cyc = s + rise;
                    be.val = code[2-b];
                    exp_bits.push_back(be);
                end
            end
        end
        if (abort_at < 0 && reset_at < 0) begin
            de.cyc = s + RUN_T;
            de.ill = ill;
            exp_done.push_back(de);
        end
        load_len = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("illegal_cleared", int'(cfg_illegal), 0);
        wait_cyc(s + 3);
        chk("illegal_first_pad", int'(cfg_illegal), int'(ill_first));
        if (restart_at >= 0) begin
            wait_cyc(s + restart_at);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (abort_at >= 0) begin
            wait_cyc(s + abort_at);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", int'(busy), 0);
            chk("abort_sclk", int'(serial_clock), 0);
            chk("abort_sload", int'(serial_load), 0);
            repeat (RUN_T) @(negedge clk);
            chk("abort_no_load", load_len, 0);
            chk("abort_no_done", done_seen, d0);
            chk("abort_illegal_kept", int'(cfg_illegal), int'(ill));
            chk("abort_bits_left", exp_bits.size(), 0);
        end else if (reset_at >= 0) begin
            wait_cyc(s + reset_at);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_outputs", int'({busy, done, serial_clock, serial_data, serial_load, cfg_illegal}), 0);
            chk("rst_addr", int'(cfg_addr), 0);
            repeat (RUN_T) @(negedge clk);
            chk("rst_no_done", done_seen, d0);
            chk("rst_bits_left", exp_bits.size(), 0);
        end else begin
            while (done_seen == d0 && cyc <= s + RUN_T + 20) @(negedge clk);
            chk("done_reached", done_seen, d0 + 1);
            chk("bits_left", exp_bits.size(), 0);
        end
    endtask

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int p = 0; p < NP; p++) cfg_mem[p] = 3'b001;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({busy, done, serial_clock, serial_data, serial_load, cfg_illegal}), 0);
        chk("reset_addr", int'(cfg_addr), 0);
        rst = 1'b0;

        // Directed: top pad illegal, then all pull-down inputs.
        cfg_mem[2] = 3'b111;
        cfg_mem[1] = 3'b110;
        cfg_mem[0] = 3'b010;
        run_load(-1, -1, -1);
        for (int p = 0; p < NP; p++) cfg_mem[p] = 3'b011;
        run_load(-1, -1, -1);

        // Random codes; every other run also re-pulses start during LOAD.
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < NP; p++) cfg_mem[p] = 3'($urandom_range(0, 7));
            run_load(-1, (r % 2 == 1) ? RUN_T - 2 : -1, -1);
        end

        // Abort in the low phase of the second pad's second bit.
        for (int p = 0; p < NP; p++) cfg_mem[p] = 3'($urandom_range(0, 7));
        run_load(3 + PAD_T + 2 * CD + 1, -1, -1);

        // Abort and start together from IDLE: abort wins.
        @(negedge clk);
        d0    = done_seen;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("abort_start_idle", int'(busy), 0);
        chk("abort_start_no_done", done_seen, d0);

        // Reset during LOAD, then a fresh load completes.
        for (int p = 0; p < NP; p++) cfg_mem[p] = 3'($urandom_range(0, 7));
        run_load(-1, -1, RUN_T - 2);
        run_load(-1, -1, -1);

        repeat (5) @(negedge clk);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
